beat_packer: RTL and testbench
==============================

Name: beat_packer

Overview:
- Width-up converter that sits directly downstream of the backward skid buffer stage.
- Consumes L-bit beats over a valid/ready handshake and packs N consecutive beats into one N*L-bit word.
- An optional last_f marker closes a partial word early, with a per-lane keep mask.
- Feeds the wide datapath stages that follow; sustains one beat per cycle with no bubbles.

Parameters:
L, 8, width of one input beat in bits
N, 4, beats per output word (N >= 1)

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  asynchronous, active-high reset
valid_f  input  1  upstream beat valid
ready_f  output  1  block can accept a beat this cycle
data_f  input  L  upstream beat data
last_f  input  1  beat is final of a packet; closes current word
valid_b  output  1  packed word valid
ready_b  input  1  downstream accepts word
data_b  output  N*L  packed word; lane k = bits [k*L +: L], lane 0 is first beat
keep_b  output  N  bit k set if lane k holds a written beat
last_b  output  1  word was closed by last_f

Behaviour:
- Interface: one clock, clk; reset rst is asynchronous and active-high.
- Reset values: valid_b=0, data_b=0, keep_b=0, last_b=0, lane counter cnt=0, state FILL.
- Reset mid-word discards all partially packed beats.
- Beat acceptance: acc_f = valid_f && ready_f. Word transfer: acc_b = valid_b && ready_b.
- The output register is also the assembly register; there is no separate accumulator.
- cnt has width max(1, clog2(N)) and ranges 0..N-1.
- State FILL (valid_b=0):
  - ready_f=1.
  - On acc_f: lane cnt <= data_f; keep_b[cnt] <= 1.
  - If cnt==N-1 or last_f: go to FULL with valid_b<=1, last_b<=last_f, cnt<=0.
  - Otherwise cnt<=cnt+1.
- State FULL (valid_b=1):
  - ready_f = ready_b. This is a combinational path, permitted because the upstream skid buffer registers it.
  - data_b, keep_b and last_b are held stable while !ready_b.
  - On acc_b without acc_f: go to FILL; data_b<=0, keep_b<=0, last_b<=0, valid_b<=0.
  - On acc_b with acc_f (simultaneous): the new beat starts the next word.
    - data_b <= data_f in lane 0, all other lanes 0; keep_b <= 1 in bit 0 only.
    - If N==1 or last_f: stay in FULL with valid_b=1 and last_b=last_f.
    - Otherwise go to FILL with cnt=1 and valid_b=0.
- Latency: the word is valid on the cycle after its closing beat is accepted. Throughput is 1 beat/cycle, including back-to-back words while ready_b=1.
- Unwritten lanes of a partial word read as zero.
- keep_b is always contiguous from bit 0.
- valid_f with ready_f=0 is not accepted; data_f/last_f are ignored that cycle.
- last_f on the Nth beat gives keep_b all ones and last_b=1. last_f on the first beat gives keep_b=1 in bit 0 only.
- ready_b=1 while valid_b=0 has no effect.
- N==1: every accepted beat goes directly to FULL; keep_b=1.
- valid_b never deasserts without acc_b. A word once presented is never altered.

Decomposition:
- Shared package holds:
  - the state enum {FILL, FULL};
  - a clog2-based CNT_W function (minimum 1);
  - a lane-slice index helper, reused by the future unpacker (width-down) stage.
- No sub-module required. Lane write-enable decode stays inline (one-hot of cnt, N wide).

Test Plan:
- Reset: assert rst asynchronously mid-cycle with 2 beats packed -> valid_b=0, keep_b=0, data_b=0 immediately; after release, first word starts at lane 0.
- Full word: L=8, N=4, beats 0x11,0x22,0x33,0x44 on consecutive cycles, ready_b=1 -> next cycle data_b=0x44332211, keep_b=4'b1111, last_b=0, valid_b for exactly 1 cycle.
- Early close: beats 0xAA, 0xBB(last_f=1) -> data_b=0x0000BBAA, keep_b=4'b0011, last_b=1; next packet starts at lane 0.
- Backpressure: word complete, ready_b=0 for 5 cycles while valid_f=1 -> ready_f=0, data_b unchanged for all 5 cycles; on ready_b=1, word transfers and beat 0x55 lands in lane 0 the same cycle.
- Streaming: 12 beats 0x01..0x0C with constant valid_f and ready_b -> 3 words 0x04030201, 0x08070605, 0x0C0B0A09 with no idle cycle between beats.
- Randomized valid_f/ready_b against a scoreboard, N=1 and N=4 -> output words equal packed input order, keep_b contiguous, no beat lost or duplicated.

Source files
------------

// File: rtl/beat_packer_pkg.sv
// Shared types and helpers for the beat packer and its sibling width converters.
// Lane slicing lives here so packer and unpacker agree on lane placement.
package beat_packer_pkg;

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } state_t;

    // Lane counter width; never narrower than one bit, even for N == 1.
    function automatic int cnt_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Low bit index of lane `lane` in a word of `width`-bit lanes.
    function automatic int lane_lo(input int lane, input int width);
        return lane * width;
    endfunction

endpackage

// File: rtl/beat_packer_if.sv
// Narrow-beat input and wide-word output handshakes of the beat packer.
// slave is the packer side; master is the side that drives beats and consumes words.
interface beat_packer_if #(
    parameter int L = 8,
    parameter int N = 4
);
    logic             valid_f;
    logic             ready_f;
    logic [L-1:0]     data_f;
    logic             last_f;
    logic             valid_b;
    logic             ready_b;
    logic [N*L-1:0]   data_b;
    logic [N-1:0]     keep_b;
    logic             last_b;

    modport slave (
        input  valid_f, data_f, last_f, ready_b,
        output ready_f, valid_b, data_b, keep_b, last_b
    );

    modport master (
        output valid_f, data_f, last_f, ready_b,
        input  ready_f, valid_b, data_b, keep_b, last_b
    );
endinterface

// File: rtl/beat_packer.sv
// Packs N L-bit beats into one N*L-bit word, last_f closes a partial word with keep mask.
// Latency: word valid the cycle after its closing beat; 1 beat/cycle, ready_f = ready_b while full.
module beat_packer
    import beat_packer_pkg::*;
#(
    parameter int L = 8,
    parameter int N = 4
) (
    input  logic          clk,
    input  logic          rst,
    beat_packer_if.slave  bus
);

    localparam int                CNT_W    = cnt_w(N);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(N - 1);

    state_t            state, state_nx;
    logic [CNT_W-1:0]  cnt, cnt_nx;
    logic [N*L-1:0]    data_q, data_nx;
    logic [N-1:0]      keep_q, keep_nx;
    logic [N-1:0]      lane_we;
    logic              last_q, last_nx;
    logic              acc_f, acc_b;

    // The output register doubles as the assembly register, so a full word stalls input.
    assign bus.ready_f = (state == FILL) ? 1'b1 : bus.ready_b;
    assign bus.valid_b = (state == FULL);
    assign bus.data_b  = data_q;
    assign bus.keep_b  = keep_q;
    assign bus.last_b  = last_q;

    assign acc_f = bus.valid_f && bus.ready_f;
    assign acc_b = bus.valid_b && bus.ready_b;

    always_comb begin
        lane_we = '0;
        for (int k = 0; k < N; k++) begin
            lane_we[k] = (cnt == CNT_W'(k));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= FILL;
            cnt    <= '0;
            data_q <= '0;
            keep_q <= '0;
            last_q <= 1'b0;
        end else begin
            state  <= state_nx;
            cnt    <= cnt_nx;
            data_q <= data_nx;
            keep_q <= keep_nx;
            last_q <= last_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        data_nx  = data_q;
        keep_nx  = keep_q;
        last_nx  = last_q;
        case (state)
            FILL: begin
                if (acc_f) begin
                    for (int k = 0; k < N; k++) begin
                        if (lane_we[k]) begin
                            data_nx[lane_lo(k, L) +: L] = bus.data_f;
                            keep_nx[k]                  = 1'b1;
                        end
                    end
                    if (cnt == CNT_LAST || bus.last_f) begin
                        state_nx = FULL;
                        last_nx  = bus.last_f;
                        cnt_nx   = '0;
                    end else begin
                        cnt_nx = cnt + CNT_W'(1);
                    end
                end
            end
            FULL: begin
                if (acc_b) begin
                    state_nx = FILL;
                    cnt_nx   = '0;
                    data_nx  = '0;
                    keep_nx  = '0;
                    last_nx  = 1'b0;
                    // A beat arriving with the handoff opens the next word in lane 0.
                    if (acc_f) begin
                        data_nx[L-1:0] = bus.data_f;
                        keep_nx[0]     = 1'b1;
                        if (N == 1 || bus.last_f) begin
                            state_nx = FULL;
                            last_nx  = bus.last_f;
                        end else begin
                            cnt_nx = CNT_W'(1);
                        end
                    end
                end
            end
            default: state_nx = FILL;
        endcase
    end

endmodule

// File: tb/tb_beat_packer.sv
// Directed and randomized checks of beat_packer at N=4 and N=1 (L=8).
// Expected words are hand-computed constants or built by a packing scoreboard.
module tb_beat_packer;

    typedef struct packed {
        logic [31:0] d;
        logic [3:0]  k;
        logic        l;
    } word_t;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_fail;

    beat_packer_if #(.L(8), .N(4)) bus4 ();
    beat_packer_if #(.L(8), .N(1)) bus1 ();

    beat_packer #(.L(8), .N(4)) u_dut4 (.clk(clk), .rst(rst), .bus(bus4));
    beat_packer #(.L(8), .N(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_chk++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat4(input logic [7:0] d, input logic l);
        bus4.valid_f = 1'b1;
        bus4.data_f  = d;
        bus4.last_f  = l;
        tick();
    endtask

    task automatic idle4();
        bus4.valid_f = 1'b0;
        bus4.last_f  = 1'b0;
    endtask

    // scoreboard state, index 0 = N4 instance, 1 = N1 instance
    word_t       q0[$];
    word_t       q1[$];
    word_t       cur[2];
    word_t       hold_w[2];
    word_t       w;
    logic        held[2];
    logic        vf[2], rf[2], vb[2], rb[2], lf[2];
    logic [7:0]  df[2];
    logic [31:0] asm_d[2];
    logic [3:0]  asm_k[2];
    int          asm_cnt[2];
    int          nbeat[2];
    int          nwords[2];
    int          qsz;

    initial begin
        logic [31:0] exp_w[3];
        exp_w = '{32'h04030201, 32'h08070605, 32'h0C0B0A09};
        n_chk  = 0;
        n_fail = 0;
        rst    = 1'b1;
        bus4.valid_f = 1'b0; bus4.data_f = '0; bus4.last_f = 1'b0; bus4.ready_b = 1'b1;
        bus1.valid_f = 1'b0; bus1.data_f = '0; bus1.last_f = 1'b0; bus1.ready_b = 1'b1;
        #3;
        chk("rst_vld",  bus4.valid_b, 1'b0);
        chk("rst_dat",  bus4.data_b,  32'h0);
        chk("rst_keep", bus4.keep_b,  4'h0);
        chk("rst_last", bus4.last_b,  1'b0);
        chk("rst_vld1", bus1.valid_b, 1'b0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // full word
        beat4(8'h11, 1'b0); beat4(8'h22, 1'b0); beat4(8'h33, 1'b0); beat4(8'h44, 1'b0);
        idle4(); #1;
        chk("full_vld",  bus4.valid_b, 1'b1);
        chk("full_dat",  bus4.data_b,  32'h44332211);
        chk("full_keep", bus4.keep_b,  4'b1111);
        chk("full_last", bus4.last_b,  1'b0);
        tick();
        chk("full_vld_1cyc", bus4.valid_b, 1'b0);
        chk("full_clr_dat",  bus4.data_b,  32'h0);
        chk("full_clr_keep", bus4.keep_b,  4'h0);

        // early close
        beat4(8'hAA, 1'b0); beat4(8'hBB, 1'b1);
        idle4(); #1;
        chk("ec_vld",  bus4.valid_b, 1'b1);
        chk("ec_dat",  bus4.data_b,  32'h0000BBAA);
        chk("ec_keep", bus4.keep_b,  4'b0011);
        chk("ec_last", bus4.last_b,  1'b1);
        tick();
        chk("ec_done", bus4.valid_b, 1'b0);

        // backpressure
        bus4.ready_b = 1'b0;
        beat4(8'hC1, 1'b0); beat4(8'hC2, 1'b0); beat4(8'hC3, 1'b0); beat4(8'hC4, 1'b0);
        bus4.valid_f = 1'b1; bus4.data_f = 8'h55; bus4.last_f = 1'b0;
        #1;
        for (int i = 0; i < 5; i++) begin
            chk("bp_rdy",  bus4.ready_f, 1'b0);
            chk("bp_vld",  bus4.valid_b, 1'b1);
            chk("bp_dat",  bus4.data_b,  32'hC4C3C2C1);
            chk("bp_keep", bus4.keep_b,  4'b1111);
            tick();
        end
        bus4.ready_b = 1'b1;
        #1;
        chk("bp_rdy_rel", bus4.ready_f, 1'b1);
        tick();
        chk("bp_nxt_vld",  bus4.valid_b, 1'b0);
        chk("bp_nxt_dat",  bus4.data_b,  32'h00000055);
        chk("bp_nxt_keep", bus4.keep_b,  4'b0001);
        beat4(8'h66, 1'b0); beat4(8'h77, 1'b0); beat4(8'h88, 1'b0);
        chk("bp_word2", bus4.data_b, 32'h88776655);

        // streaming: 12 beats with no gaps, first one overlaps the pending word
        for (int i = 1; i <= 12; i++) begin
            bus4.valid_f = 1'b1;
            bus4.data_f  = 8'(i);
            bus4.last_f  = 1'b0;
            #1;
            chk("stream_rdy", bus4.ready_f, 1'b1);
            tick();
            chk("stream_vld", bus4.valid_b, (i % 4) == 0);
            if ((i % 4) == 0) chk("stream_dat", bus4.data_b, exp_w[i/4 - 1]);
        end
        idle4();
        tick();
        chk("stream_end", bus4.valid_b, 1'b0);

        // last_f on the Nth beat
        beat4(8'h01, 1'b0); beat4(8'h02, 1'b0); beat4(8'h03, 1'b0); beat4(8'h04, 1'b1);
        idle4(); #1;
        chk("lastn_keep", bus4.keep_b, 4'b1111);
        chk("lastn_last", bus4.last_b, 1'b1);
        chk("lastn_dat",  bus4.data_b, 32'h04030201);
        tick();

        // asynchronous reset with two beats packed
        beat4(8'h77, 1'b0); beat4(8'h66, 1'b0);
        idle4(); #1;
        chk("prerst_keep", bus4.keep_b, 4'b0011);
        chk("prerst_dat",  bus4.data_b, 32'h00006677);
        #2 rst = 1'b1;
        #1;
        chk("arst_vld",  bus4.valid_b, 1'b0);
        chk("arst_keep", bus4.keep_b,  4'h0);
        chk("arst_dat",  bus4.data_b,  32'h0);
        #2 rst = 1'b0;
        beat4(8'h99, 1'b1);
        idle4(); #1;
        chk("postrst_vld",  bus4.valid_b, 1'b1);
        chk("postrst_dat",  bus4.data_b,  32'h00000099);
        chk("postrst_keep", bus4.keep_b,  4'b0001);
        chk("postrst_last", bus4.last_b,  1'b1);
        tick();

        // N == 1 goes straight to FULL
        bus1.valid_f = 1'b1; bus1.data_f = 8'h5A; bus1.last_f = 1'b0;
        tick();
        bus1.valid_f = 1'b0;
        #1;
        chk("n1_vld",  bus1.valid_b, 1'b1);
        chk("n1_dat",  bus1.data_b,  8'h5A);
        chk("n1_keep", bus1.keep_b,  1'b1);
        chk("n1_last", bus1.last_b,  1'b0);
        tick();
        chk("n1_done", bus1.valid_b, 1'b0);

        // randomized handshakes against a packing scoreboard
        rst = 1'b1;
        #1 rst = 1'b0;
        nbeat[0] = 4;
        nbeat[1] = 1;
        for (int d = 0; d < 2; d++) begin
            held[d] = 1'b0; asm_d[d] = '0; asm_k[d] = '0; asm_cnt[d] = 0; nwords[d] = 0;
        end
        for (int c = 0; c < 700; c++) begin
            for (int d = 0; d < 2; d++) begin
                if (c < 680) begin
                    vf[d] = ($urandom_range(0, 3) != 0);
                    rb[d] = ($urandom_range(0, 2) != 0);
                end else begin
                    vf[d] = 1'b0;
                    rb[d] = 1'b1;
                end
                df[d] = 8'($urandom_range(0, 255));
                lf[d] = ($urandom_range(0, 7) == 0);
            end
            bus4.valid_f = vf[0]; bus4.data_f = df[0]; bus4.last_f = lf[0]; bus4.ready_b = rb[0];
            bus1.valid_f = vf[1]; bus1.data_f = df[1]; bus1.last_f = lf[1]; bus1.ready_b = rb[1];
            #1;
            rf[0] = bus4.ready_f; vb[0] = bus4.valid_b;
            cur[0] = '{d: bus4.data_b, k: bus4.keep_b, l: bus4.last_b};
            rf[1] = bus1.ready_f; vb[1] = bus1.valid_b;
            cur[1] = '{d: 32'(bus1.data_b), k: 4'(bus1.keep_b), l: bus1.last_b};
            for (int d = 0; d < 2; d++) begin
                if (held[d]) begin
                    chk("hold_vld",  vb[d],  1'b1);
                    chk("hold_word", cur[d], hold_w[d]);
                end
                held[d]   = vb[d] && !rb[d];
                hold_w[d] = cur[d];
                if (vb[d] && rb[d]) begin
                    qsz = (d == 0) ? q0.size() : q1.size();
                    chk("sb_pending", qsz != 0, 1'b1);
                    if (qsz != 0) begin
                        if (d == 0) w = q0.pop_front();
                        else        w = q1.pop_front();
                        chk("sb_data", cur[d].d, w.d);
                        chk("sb_keep", cur[d].k, w.k);
                        chk("sb_last", cur[d].l, w.l);
                        nwords[d]++;
                    end
                end
                if (vf[d] && rf[d]) begin
                    asm_d[d][8*asm_cnt[d] +: 8] = df[d];
                    asm_k[d][asm_cnt[d]]        = 1'b1;
                    asm_cnt[d]++;
                    if (asm_cnt[d] == nbeat[d] || lf[d]) begin
                        w = '{d: asm_d[d], k: asm_k[d], l: lf[d]};
                        if (d == 0) q0.push_back(w);
                        else        q1.push_back(w);
                        asm_d[d] = '0; asm_k[d] = '0; asm_cnt[d] = 0;
                    end
                end
            end
            tick();
        end
        chk("sb_drain4", q0.size(), 0);
        chk("sb_drain1", q1.size(), 0);
        chk("sb_words4", nwords[0] > 20, 1'b1);
        chk("sb_words1", nwords[1] > 20, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
